// File: rtl/add_pkg.sv
// add_pkg: shared defaults and segment-count helper for add_pipe
package add_pkg;
  localparam int WIDTH_DEF     = 37;
  localparam int SEG_WIDTH_DEF = 12;
  function automatic int seg_count(input int width, input int seg_width);
    return (width + seg_width - 1) / seg_width;
  endfunction
endpackage

// File: rtl/add_seg.sv
// add_seg: combinational ripple-carry adder for one pipeline segment
module add_seg
  import add_pkg::*;
#(
  parameter int SEG_WIDTH = SEG_WIDTH_DEF
) (
  input  logic [SEG_WIDTH-1:0] i_a,
  input  logic [SEG_WIDTH-1:0] i_b,
  input  logic                 i_c,
  output logic [SEG_WIDTH-1:0] o_s,
  output logic                 o_c
);
  for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
    logic w_ci, w_co;
    if (i == 0) begin : g_c
      assign w_ci = i_c;
    end else begin : g_c
      assign w_ci = g_bit[i-1].w_co;
    end
    full_adder u_fa (.i_a(i_a[i]), .i_b(i_b[i]), .i_c(w_ci), .o_s(o_s[i]), .o_c(w_co));
  end
  assign o_c = g_bit[SEG_WIDTH-1].w_co;
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/add_pipe.sv
// add_pipe: segmented carry-chain pipelined adder/subtractor with valid/ready flow control
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEG_WIDTH = SEG_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_one,
  input  logic [WIDTH-1:0] i_data_two,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_overflow
);
  localparam int NSEG = seg_count(WIDTH, SEG_WIDTH);
  logic [NSEG-1:0]  r_v, r_c, w_en, w_v_in, w_c_in, w_co;
  logic [WIDTH-1:0] r_a [NSEG];
  logic [WIDTH-1:0] r_b [NSEG];
  logic [WIDTH-1:0] r_s [NSEG];
  logic [WIDTH-1:0] w_a_in [NSEG];
  logic [WIDTH-1:0] w_b_in [NSEG];
  logic [WIDTH-1:0] w_s_in [NSEG];
  logic [WIDTH-1:0] w_s_nx [NSEG];
  logic             r_ov, w_ov;
  assign w_v_in = NSEG'({r_v, i_valid});
  assign w_c_in = NSEG'({r_c, i_carry ^ i_sub});
  // stage inputs: stage 0 sees the ports with subtract folded into B, later stages see their predecessor
  always_comb begin
    w_a_in[0] = i_data_one;
    w_b_in[0] = i_sub ? ~i_data_two : i_data_two;
    w_s_in[0] = '0;
    for (int k = 1; k < NSEG; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
    end
  end
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO = k * SEG_WIDTH;
    localparam int SW = (WIDTH - LO < SEG_WIDTH) ? WIDTH - LO : SEG_WIDTH;
    logic [SW-1:0] w_sum;
    add_seg #(.SEG_WIDTH(SW)) u_seg (
      .i_a(w_a_in[k][LO +: SW]),
      .i_b(w_b_in[k][LO +: SW]),
      .i_c(w_c_in[k]),
      .o_s(w_sum),
      .o_c(w_co[k])
    );
    assign w_s_nx[k] = w_s_in[k] | (WIDTH'(w_sum) << LO);
  end
  assign w_ov = (w_a_in[NSEG-1][WIDTH-1] == w_b_in[NSEG-1][WIDTH-1]) &&
                (w_s_nx[NSEG-1][WIDTH-1] != w_a_in[NSEG-1][WIDTH-1]);
  // a stage loads when empty or when its own content moves on this cycle, chained back from i_ready
  always_comb begin : p_en
    logic w_nx;
    w_nx = i_ready;
    w_en = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      w_nx    = !r_v[k] || w_nx;
      w_en[k] = w_nx;
    end
  end
  // stage registers: valid bits and results clear on reset, operands just follow the load enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v  <= '0;
      r_c  <= '0;
      r_ov <= 1'b0;
      for (int k = 0; k < NSEG; k++) r_s[k] <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++)
        if (w_en[k]) begin
          r_v[k] <= w_v_in[k];
          r_c[k] <= w_co[k];
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_nx[k];
        end
      if (w_en[NSEG-1]) r_ov <= w_ov;
    end
  end
  assign o_ready    = w_en[0];
  assign o_valid    = r_v[NSEG-1];
  assign o_data     = r_s[NSEG-1];
  assign o_carry    = r_c[NSEG-1];
  assign o_overflow = r_ov;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: checks add_pipe at default, single-segment and three-segment geometries against a behavioural model
module tb_add_pipe;
  typedef struct {
    logic [63:0] d;
    logic        c;
    logic        ov;
    int          t;
  } exp_t;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [2:0]  v = '0, rdy = '1, ci = '0, sb = '0;
  logic [63:0] a [3];
  logic [63:0] b [3];
  logic [2:0]  vo, ro, co, ovo;
  logic [36:0] d0;
  logic [7:0]  d1, d2;
  exp_t        q [3][$];
  logic [2:0]  held = '0;
  logic [63:0] hd [3];
  logic [1:0]  hf [3];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  always #5 i_clk = ~i_clk;
  add_pipe u0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(v[0]), .o_ready(ro[0]),
    .i_data_one(a[0][36:0]), .i_data_two(b[0][36:0]), .i_carry(ci[0]), .i_sub(sb[0]),
    .o_valid(vo[0]), .i_ready(rdy[0]), .o_data(d0), .o_carry(co[0]), .o_overflow(ovo[0])
  );
  add_pipe #(.WIDTH(8), .SEG_WIDTH(8)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(v[1]), .o_ready(ro[1]),
    .i_data_one(a[1][7:0]), .i_data_two(b[1][7:0]), .i_carry(ci[1]), .i_sub(sb[1]),
    .o_valid(vo[1]), .i_ready(rdy[1]), .o_data(d1), .o_carry(co[1]), .o_overflow(ovo[1])
  );
  add_pipe #(.WIDTH(8), .SEG_WIDTH(3)) u2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(v[2]), .o_ready(ro[2]),
    .i_data_one(a[2][7:0]), .i_data_two(b[2][7:0]), .i_carry(ci[2]), .i_sub(sb[2]),
    .o_valid(vo[2]), .i_ready(rdy[2]), .o_data(d2), .o_carry(co[2]), .o_overflow(ovo[2])
  );
  function automatic int wid(input int i);
    return i == 0 ? 37 : 8;
  endfunction
  function automatic int nsg(input int i);
    return i == 0 ? 4 : i == 1 ? 1 : 3;
  endfunction
  function automatic logic [63:0] dout(input int i);
    return i == 0 ? 64'(d0) : i == 1 ? 64'(d1) : 64'(d2);
  endfunction
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c,
                                 input logic s, input int w);
    exp_t e;
    longint m, h, ua, ub, sa, sv, cc, full, ss;
    m    = (longint'(1) << w) - 1;
    h    = longint'(1) << (w - 1);
    ua   = longint'(x) & m;
    ub   = longint'(y) & m;
    sa   = ua >= h ? ua - m - 1 : ua;
    sv   = ub >= h ? ub - m - 1 : ub;
    cc   = c ? 1 : 0;
    full = s ? ua - ub - cc : ua + ub + cc;
    ss   = s ? sa - sv - cc : sa + sv + cc;
    e.d  = 64'(full & m);
    e.c  = s ? (full >= 0) : (full > m);
    e.ov = (ss < -h) || (ss >= h);
    e.t  = 0;
    return e;
  endfunction
  task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, id, got, exp);
    end
  endtask
  initial begin : cmp
    logic [63:0] od;
    logic        ev;
    exp_t        e;
    forever begin
      @(negedge i_clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (i_rst) begin
          q[i].delete();
          held[i] = 1'b0;
        end else begin
          od = dout(i);
          ev = q[i].size() > 0 && (cyc - q[i][0].t) >= nsg(i);
          chk("o_valid", i, 64'(vo[i]), 64'(ev));
          chk("o_ready", i, 64'(ro[i]), 64'(q[i].size() < nsg(i) || rdy[i]));
          if (held[i] && vo[i]) begin
            chk("hold_data", i, od, hd[i]);
            chk("hold_flags", i, 64'({co[i], ovo[i]}), 64'(hf[i]));
          end
          if (vo[i] && q[i].size() > 0) begin
            chk("o_data", i, od, q[i][0].d);
            chk("o_carry", i, 64'(co[i]), 64'(q[i][0].c));
            chk("o_overflow", i, 64'(ovo[i]), 64'(q[i][0].ov));
            if (rdy[i]) void'(q[i].pop_front());
          end
          held[i] = vo[i] && !rdy[i];
          hd[i]   = od;
          hf[i]   = {co[i], ovo[i]};
          if (v[i] && ro[i]) begin
            e   = model(a[i], b[i], ci[i], sb[i], wid(i));
            e.t = cyc;
            q[i].push_back(e);
          end
        end
      end
    end
  end
  task automatic send(input int id, input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
    bit acc;
    acc    = 1'b0;
    a[id]  = x;
    b[id]  = y;
    ci[id] = c;
    sb[id] = s;
    v[id]  = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge i_clk);
      acc = ro[id];
      @(posedge i_clk);
      #1;
    end
    v[id] = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: o_ready stayed 0, required 1", id);
    end
  endtask
  task automatic directed(input int id, input logic [63:0] x, input logic [63:0] y, input logic c,
                          input logic s, input logic [63:0] ed, input logic ec, input logic eo);
    exp_t m;
    m = model(x, y, c, s, wid(id));
    chk("model_data", id, m.d, ed);
    chk("model_carry", id, 64'(m.c), 64'(ec));
    chk("model_ovf", id, 64'(m.ov), 64'(eo));
    send(id, x, y, c, s);
    for (int k = 1; k <= nsg(id); k++) begin
      @(negedge i_clk);
      chk("latency_valid", id, 64'(vo[id]), 64'(k == nsg(id)));
    end
    chk("lit_data", id, dout(id), ed);
    chk("lit_carry", id, 64'(co[id]), 64'(ec));
    chk("lit_ovf", id, 64'(ovo[id]), 64'(eo));
    @(posedge i_clk);
    #1;
  endtask
  task automatic drain(input int id);
    for (int k = 0; k < 300 && q[id].size() > 0; k++) @(posedge i_clk);
    if (q[id].size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout dut%0d: %0d results outstanding, required 0", id, q[id].size());
    end
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", 0, 64'(vo[0]), 0);
    chk("rst_ready", 0, 64'(ro[0]), 1);
    chk("rst_data", 0, 64'(d0), 0);
    chk("rst_carry", 0, 64'(co[0]), 0);
    chk("rst_ovf", 0, 64'(ovo[0]), 0);
    chk("rst_data", 2, 64'(d2), 0);
    @(posedge i_clk);
    #1;
    directed(0, 64'h1F_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    directed(0, 64'h5, 64'h7, 1'b0, 1'b1, 64'h1F_FFFF_FFFE, 1'b0, 1'b0);
    directed(0, 64'h0F_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h10_0000_0000, 1'b0, 1'b1);
    directed(0, 64'h10_0000_0000, 64'h1, 1'b0, 1'b1, 64'h0F_FFFF_FFFF, 1'b1, 1'b1);
    fork
      for (int k = 0; k < 100; k++)
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge i_clk);
        #1 rdy[0] = 1'b0;
        repeat (6) @(posedge i_clk);
        #1 rdy[0] = 1'b1;
      end
    join
    drain(0);
    for (int k = 0; k < 3; k++)
      send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_valid", 0, 64'(vo[0]), 0);
    chk("midrst_ready", 0, 64'(ro[0]), 1);
    repeat (6) @(posedge i_clk);
    #1;
    directed(0, 64'h12_3456_789A, 64'h0F_EDCB_A987, 1'b0, 1'b0, 64'h02_2222_2221, 1'b1, 1'b0);
    directed(1, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
    directed(2, 64'h00, 64'h01, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0);
    directed(2, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      fork
        for (int k = 0; k < 60; k++) begin
          send(i, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge i_clk);
            #1;
          end
        end
        for (int k = 0; k < 120; k++) begin
          rdy[i] = ($urandom_range(0, 3) != 0);
          @(posedge i_clk);
          #1;
        end
      join
      rdy[i] = 1'b1;
      drain(i);
    end
    repeat (3) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 37: operand and result width in bits, legal range 2..128.
REQ-002 Parameter SEG_WIDTH, default 12: carry-chain segment width, legal range 1..WIDTH. NSEG = ceil(WIDTH/SEG_WIDTH); the top segment holds the remaining bits.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port i_rst, input, 1: synchronous, active-high reset.
REQ-005 Port i_valid, input, 1: the input transaction is present.
REQ-006 Port o_ready, output, 1: the block can accept an input this cycle.
REQ-007 Port i_data_one, input, WIDTH: operand A.
REQ-008 Port i_data_two, input, WIDTH: operand B.
REQ-009 Port i_carry, input, 1: carry-in in add mode; borrow-in in subtract mode.
REQ-010 Port i_sub, input, 1: 0 selects add, 1 selects subtract.
REQ-011 Port o_valid, output, 1: the result is present.
REQ-012 Port i_ready, input, 1: downstream accepts the result.
REQ-013 Port o_data, output, WIDTH: the result.
REQ-014 Port o_carry, output, 1: carry-out; in subtract mode this is the inverted borrow.
REQ-015 Port o_overflow, output, 1: two's-complement signed overflow of the result.

Function
REQ-016 An input transfer occurs when i_valid and o_ready are both 1; an output transfer occurs when o_valid and i_ready are both 1.
REQ-017 Add mode computes {o_carry,o_data} = A + B + i_carry.
REQ-018 Subtract mode computes A + ~B + ~i_carry, i.e. A - B - i_carry; o_carry = 1 means no borrow occurred.
REQ-019 o_overflow = 1 when both effective operands (A and B, or A and ~B) have equal sign bits and the result sign differs from them.
REQ-020 Pipeline structure:
- Stage k (0..NSEG-1) adds segment k using the carry registered by stage k-1.
- Stage 0 uses the effective carry-in.
- Operand bits above segment k are carried forward in registers; completed result segments are carried forward with them.
- Mode and carry are registered with the data.
REQ-021 Latency is exactly NSEG cycles from an input transfer to o_valid, provided i_ready stays 1.
REQ-022 Sustained throughput is one transaction per cycle when i_ready stays 1.
REQ-023 Each stage holds a valid bit. A stage loads from its predecessor when it is empty, or when its own content moves on in the same cycle (bubble collapsing).
REQ-024 o_ready = NOT stage0_valid OR stage0 advances this cycle; o_ready is combinational on i_ready through the advance chain.
REQ-025 While o_valid = 1 and i_ready = 0:
- o_data, o_carry and o_overflow hold stable.
- Upstream stages fill any bubbles and then stall; no transaction is lost or duplicated.
REQ-026 Transactions leave in the order they were accepted.
REQ-027 When WIDTH equals SEG_WIDTH, NSEG = 1 and the latency is 1.

Reset
REQ-028 While i_rst = 1 at a clock edge, all stage valid bits clear, so o_valid = 0 and o_ready = 1 on the next cycle.
REQ-029 At the same reset edge, o_data, o_carry and o_overflow clear to 0; other datapath registers need no reset.
REQ-030 Reset asserted mid-stream discards all in-flight transactions; the first transfer after deassertion produces the next valid result.

Structure
REQ-031 The shared package add_pkg holds the default WIDTH and SEG_WIDTH values and a function returning NSEG.
REQ-032 Sub-module add_seg is a combinational segment adder: SEG_WIDTH-bit operands plus carry-in, giving sum and carry-out. It is built from the existing full_adder cells and is instantiated once per stage through a generate loop.
REQ-033 No vendor primitives; the block is synthesizable as written.

Verification
REQ-034 Defaults (WIDTH=37, NSEG=4), add mode: A=0x1F_FFFF_FFFF, B=0, i_carry=1 -> o_data=0, o_carry=1, o_overflow=0, with o_valid exactly 4 cycles after the transfer.
REQ-035 Defaults, subtract mode: A=5, B=7, i_carry=0 -> o_data=0x1F_FFFF_FFFE, o_carry=0, o_overflow=0.
REQ-036 Defaults, add mode: A=0x0F_FFFF_FFFF, B=1, i_carry=0 -> o_data=0x10_0000_0000, o_overflow=1.
REQ-037 Stream 100 random back-to-back transactions with i_ready held low for cycles 3..8:
- Results match the reference model in order.
- Outputs hold stable while stalled.
- o_ready drops only once all 4 stages are full.
REQ-038 Assert i_rst for one cycle with 3 transactions in flight -> o_valid = 0 on the next cycle and none of the 3 results ever appear; a new transfer then completes with latency 4.
REQ-039 Sweep of random add and subtract transactions with WIDTH=8, SEG_WIDTH=8, then WIDTH=8, SEG_WIDTH=3 -> latency 1 and 3 respectively, with all results correct.
